// File: rtl/cnu_beta_gen.sv
// Check-node output stage: expands one compressed min-sum result (min1/min2/idx/signs)
// into DMAX offset-corrected beta messages, streamed one edge per beat.
module cnu_beta_gen #(
  parameter  int unsigned BITS   = 8,
  parameter  int unsigned DMAX   = 7,
  parameter  int unsigned OFFSET = 1,
  localparam int unsigned IDXW   = $clog2(DMAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_min1,
  input  logic [BITS-1:0] in_min2,
  input  logic [IDXW-1:0] in_idx,
  input  logic [DMAX-1:0] in_sign,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_beta,
  output logic [IDXW-1:0] out_edge,
  output logic            out_last
);

  localparam int unsigned     MW     = BITS - 1;
  localparam logic [MW-1:0]   OFF    = MW'(OFFSET);
  localparam logic [IDXW-1:0] LAST_E = IDXW'(DMAX - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   min1_q, min2_q;
  logic [IDXW-1:0] idx_q;
  logic [DMAX-1:0] sign_q;
  logic            par_q;

  logic            load, adv;
  logic [MW-1:0]   min1_src, min2_src;
  logic [IDXW-1:0] idx_src;
  logic [DMAX-1:0] sign_src;
  logic            par_src;
  logic [IDXW-1:0] edge_d;
  logic [BITS-1:0] beta_d;

  // Magnitude MSBs are ignored by definition; keep them visibly consumed.
  logic unused_msb;
  assign unused_msb = in_min1[BITS-1] ^ in_min2[BITS-1];

  // Offset-min-sum beta for edge e of a row.
  function automatic logic [BITS-1:0] beta_calc(
    input logic [MW-1:0]   m1,
    input logic [MW-1:0]   m2,
    input logic [IDXW-1:0] ix,
    input logic [DMAX-1:0] sg,
    input logic            par,
    input logic [IDXW-1:0] e
  );
    logic [MW-1:0] m;
    logic [MW-1:0] mag;
    logic          s;
    m   = (e == ix) ? m2 : m1;
    mag = (m > OFF) ? m - OFF : '0;
    s   = par ^ sg[e];
    beta_calc = s ? -{1'b0, mag} : {1'b0, mag};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EMIT;
      EMIT:    if (out_ready && out_last && !in_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      EMIT: begin
        out_valid = 1'b1;
        in_ready  = out_last & out_ready;
      end
      default: ;
    endcase
  end

  // Next beat: a freshly accepted row starts at edge 0 straight from the inputs.
  always_comb begin
    load     = in_valid & in_ready;
    adv      = out_valid & out_ready & ~out_last;
    min1_src = load ? in_min1[MW-1:0] : min1_q;
    min2_src = load ? in_min2[MW-1:0] : min2_q;
    idx_src  = load ? in_idx : idx_q;
    sign_src = load ? in_sign : sign_q;
    par_src  = load ? ^in_sign : par_q;
    if (load)     edge_d = '0;
    else if (adv) edge_d = out_edge + IDXW'(1);
    else          edge_d = out_edge;
    beta_d = beta_calc(min1_src, min2_src, idx_src, sign_src, par_src, edge_d);
  end

  // Row latch and registered beat outputs; everything holds on a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      min1_q   <= '0;
      min2_q   <= '0;
      idx_q    <= '0;
      sign_q   <= '0;
      par_q    <= 1'b0;
      out_beta <= '0;
      out_edge <= '0;
      out_last <= 1'b0;
    end else begin
      if (load) begin
        min1_q <= min1_src;
        min2_q <= min2_src;
        idx_q  <= idx_src;
        sign_q <= sign_src;
        par_q  <= par_src;
      end
      if (load || adv) begin
        out_beta <= beta_d;
        out_edge <= edge_d;
        out_last <= (edge_d == LAST_E);
      end
    end
  end

endmodule

// File: tb/tb_cnu_beta_gen.sv
// Bench for cnu_beta_gen: directed vector table, multi-cycle corner sequences and
// a randomized run against a behavioural scoreboard.
module tb_cnu_beta_gen;

  localparam int DMAX   = 7;
  localparam int OFFSET = 1;
  localparam int NROWS  = 2500;
  localparam int BUDGET = 60000;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_min1;
  logic [7:0] in_min2;
  logic [2:0] in_idx;
  logic [6:0] in_sign;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_beta;
  logic [2:0] out_edge;
  logic       out_last;

  int total = 0;
  int bad   = 0;

  cnu_beta_gen dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_beta(out_beta), .out_edge(out_edge), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] m1;
    logic [7:0] m2;
    logic [2:0] ix;
    logic [6:0] sg;
    int         exp [7];
  } vec_t;

  typedef struct {
    int e;
    int b;
    bit l;
  } beat_t;

  vec_t  vecs [5];
  beat_t expq [$];

  task automatic check(input string name, input bit ok, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge=%0d valid=%0b last=%0b t=%0t)",
               name, act, exp, out_edge, out_valid, out_last, $time);
    end
  endtask

  // Reference beta: magnitude from min1 or min2, sign = parity of all other edges.
  function automatic int ref_beta(input logic [7:0] m1, input logic [7:0] m2,
                                  input logic [2:0] ix, input logic [6:0] sg, input int k);
    int m;
    int mag;
    int others;
    m      = (k == int'(ix)) ? int'(m2[6:0]) : int'(m1[6:0]);
    mag    = (m > OFFSET) ? m - OFFSET : 0;
    others = $countones(sg) - int'(sg[k]);
    return (others % 2 == 1) ? -mag : mag;
  endfunction

  function automatic int beta_now();
    return int'($signed(out_beta));
  endfunction

  task automatic drive_row(input logic [7:0] m1, input logic [7:0] m2,
                           input logic [2:0] ix, input logic [6:0] sg);
    in_min1 = m1;
    in_min2 = m2;
    in_idx  = ix;
    in_sign = sg;
  endtask

  // One table row: present, accept, then collect DMAX beats with out_ready held high.
  task automatic do_vec(input int v);
    bit ok;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    drive_row(vecs[v].m1, vecs[v].m2, vecs[v].ix, vecs[v].sg);
    @(negedge clk);
    check($sformatf("vec%0d_in_ready", v), in_ready == 1'b1, int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive_row(8'($urandom), 8'($urandom), 3'($urandom), 7'($urandom));
    for (int k = 0; k < DMAX; k++) begin
      @(negedge clk);
      ok = out_valid && int'(out_edge) == k && beta_now() == vecs[v].exp[k] &&
           out_last == (k == DMAX - 1);
      check($sformatf("vec%0d_e%0d", v, k), ok, beta_now(), vecs[v].exp[k]);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check($sformatf("vec%0d_idle", v), !out_valid && in_ready, int'(out_valid), 0);
  endtask

  initial begin
    bit         ok;
    bit         held;
    bit         acc;
    int         nb;
    int         sent;
    int         cyc;
    int         hb;
    int         he;
    bit         hl;
    int         eb;
    beat_t      bt;
    bit         pat [4];
    logic [7:0] b_m1;
    logic [7:0] b_m2;
    logic [2:0] b_ix;
    logic [6:0] b_sg;

    vecs[0] = '{8'd3,    8'd5,    3'd2, 7'b0000101, '{-2, 2, -4, 2, 2, 2, 2}};
    vecs[1] = '{8'd1,    8'h7F,   3'd6, 7'b0000001, '{0, 0, 0, 0, 0, 0, -126}};
    vecs[2] = '{8'h85,   8'd9,    3'd7, 7'b1111111, '{4, 4, 4, 4, 4, 4, 4}};
    vecs[3] = '{8'd0,    8'd2,    3'd0, 7'b0110000, '{1, 0, 0, 0, 0, 0, 0}};
    vecs[4] = '{8'h7F,   8'h7F,   3'd3, 7'b1000000, '{-126, -126, -126, -126, -126, -126, 126}};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_row(8'd0, 8'd0, 3'd0, 7'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    check("rst_in_ready",  in_ready == 1'b1,  int'(in_ready), 1);
    check("rst_out_beta",  out_beta == 8'd0,  beta_now(), 0);
    check("rst_out_edge",  out_edge == 3'd0,  int'(out_edge), 0);
    check("rst_out_last",  out_last == 1'b0,  int'(out_last), 0);

    // Directed table (T1, T2, illegal idx / MSB set, zero clamp, full-scale).
    for (int v = 0; v < 5; v++) do_vec(v);

    // Back-to-back rows: 14 beats with no bubble, in_ready high on each last beat.
    b_m1 = 8'd10; b_m2 = 8'd20; b_ix = 3'd5; b_sg = 7'b1100110;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    drive_row(vecs[0].m1, vecs[0].m2, vecs[0].ix, vecs[0].sg);
    @(posedge clk); #1;
    drive_row(b_m1, b_m2, b_ix, b_sg);
    for (int j = 0; j < 2 * DMAX; j++) begin
      @(negedge clk);
      eb = (j < DMAX) ? vecs[0].exp[j % DMAX] : ref_beta(b_m1, b_m2, b_ix, b_sg, j % DMAX);
      ok = out_valid && int'(out_edge) == j % DMAX && beta_now() == eb &&
           out_last == (j % DMAX == DMAX - 1) && in_ready == (j % DMAX == DMAX - 1);
      check($sformatf("b2b_beat%0d", j), ok, beta_now(), eb);
      @(posedge clk); #1;
      if (j == DMAX - 1) in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle", !out_valid && in_ready, int'(out_valid), 0);

    // Stalls with out_ready pattern 1,0,0,1: outputs frozen, every edge once, in order.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    drive_row(vecs[0].m1, vecs[0].m2, vecs[0].ix, vecs[0].sg);
    @(posedge clk); #1;
    in_valid = 1'b0;
    nb = 0; held = 1'b0; hb = 0; he = 0; hl = 1'b0;
    for (int c = 0; c < 40 && nb < DMAX; c++) begin
      out_ready = pat[c % 4];
      @(negedge clk);
      if (held) begin
        ok = out_valid && beta_now() == hb && int'(out_edge) == he && out_last == hl;
        check("stall_hold", ok, beta_now(), hb);
      end
      if (out_valid && out_ready) begin
        ok = int'(out_edge) == nb && beta_now() == vecs[0].exp[nb] && out_last == (nb == DMAX - 1);
        check($sformatf("stall_e%0d", nb), ok, beta_now(), vecs[0].exp[nb]);
        nb++;
      end
      held = out_valid && !out_ready;
      hb = beta_now(); he = int'(out_edge); hl = out_last;
      @(posedge clk); #1;
    end
    check("stall_beat_count", nb == DMAX, nb, DMAX);
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_idle", !out_valid && in_ready, int'(out_valid), 0);

    // Reset in the middle of a row, while edge 3 is on the output.
    @(posedge clk); #1;
    in_valid = 1'b1;
    drive_row(vecs[0].m1, vecs[0].m2, vecs[0].ix, vecs[0].sg);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_pre_edge", out_valid && out_edge == 3'd3, int'(out_edge), 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    check("mid_rst_in_ready",  in_ready == 1'b1,  int'(in_ready), 1);
    check("mid_rst_out_edge",  out_edge == 3'd0,  int'(out_edge), 0);
    check("mid_rst_out_beta",  out_beta == 8'd0,  beta_now(), 0);
    do_vec(0);

    // Randomized rows, random gaps and random back-pressure against the scoreboard.
    sent = 0; cyc = 0; acc = 1'b0; held = 1'b0;
    in_valid = 1'b0;
    while ((sent < NROWS || in_valid || expq.size() != 0) && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        in_valid = 1'b0;
        acc = 1'b0;
      end
      if (!in_valid && sent < NROWS && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        drive_row(8'($urandom), 8'($urandom), 3'($urandom), 7'($urandom));
        sent++;
      end
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (held) begin
        ok = out_valid && beta_now() == hb && int'(out_edge) == he && out_last == hl;
        check("rand_stall_hold", ok, beta_now(), hb);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("rand_extra_beat", 1'b0, int'(out_edge), -1);
        end else begin
          bt = expq.pop_front();
          ok = int'(out_edge) == bt.e && beta_now() == bt.b && out_last == bt.l;
          check("rand_beat", ok, beta_now(), bt.b);
        end
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < DMAX; k++)
          expq.push_back('{k, ref_beta(in_min1, in_min2, in_idx, in_sign, k), k == DMAX - 1});
        acc = 1'b1;
      end
      held = out_valid && !out_ready;
      hb = beta_now(); he = int'(out_edge); hl = out_last;
    end
    if (cyc >= BUDGET) check("rand_timeout", 1'b0, expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
